regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Round-robin arbiter that shares the processor's single 8-entry register-file write port among N_REQ requesters (ALU, load unit, immediate path, I/O).
- Each cycle, grants at most one pending request.
- Decodes the winner's 3-bit register address into a registered one-hot write-enable vector and registers the data alongside it.
- Keeps a sticky per-register "written" bitmap for the control unit.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, register data width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  request per requester; held until granted
req_addr  in  3*N_REQ  target register of requester i at bits [3i+2:3i]
req_data  in  DATA_W*N_REQ  write data of requester i at bits [DATA_W*i+DATA_W-1:DATA_W*i]
stall  in  1  1 = issue no grants this cycle
gnt  out  N_REQ  combinational one-hot grant; transfer occurs at rising edge where req[i]&gnt[i]
wr_en  out  8  registered one-hot register-file write enable
wr_data  out  DATA_W  registered write data
wr_idx  out  3  registered address of the current write (valid when |wr_en)
written  out  8  sticky bitmap: bit k set once register k has been written
written_clr  in  1  synchronous clear of written

Behaviour:
- Reset (rst_n=0, asynchronous): ptr=0, wr_en=0, wr_data=0, wr_idx=0, written=0. gnt=0 while rst_n=0.
- Pointer:
  - ptr (width clog2(N_REQ), min 1) is the highest-priority requester.
  - Search order is ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1 (modulo N_REQ).
- Grant (combinational):
  - gnt = one-hot of the first requester in search order with req=1.
  - gnt = 0 if stall=1 or req=0.
  - gnt never has more than one bit set.
- On an edge where a grant is made to requester w:
  - ptr <= (w+1) mod N_REQ.
  - wr_en <= one-hot decode of req_addr[w] (bit a set for address a).
  - wr_data <= req_data[w]; wr_idx <= req_addr[w].
  - written[req_addr[w]] <= 1.
- No grant (stall=1 or req=0): wr_en <= 0; wr_data and wr_idx hold; ptr holds.
- Latency: exactly one cycle from the granting edge-cycle to wr_en, so one write per cycle at full throughput.
- Back-to-back same requester: after a grant, ptr moves past it, so it wins again only if no other requester is pending.
- Simultaneous written_clr with a write: clear applies first, then the bit for the write target is set. Result = only that bit set.
- Same register targeted by two requesters: served in round-robin order on consecutive cycles; the later write wins in the register file. No merging.
- req dropped before grant: the request is withdrawn, with no side effects.
- Reset asserted mid-operation: outputs clear immediately. A pending write whose wr_en has not yet been registered is lost.
- Requester i must keep req_addr/req_data stable while req[i]=1 and gnt[i]=0.

Test Plan:
- Reset: assert rst_n=0 while req=4'b1111 -> gnt=0, wr_en=0, written=0. Release -> first grant gnt=4'b0001.
- Single request: req=4'b0100, req_addr[2]=3'd5, data=8'hA7 -> gnt=4'b0100 that cycle; next cycle wr_en=8'b0010_0000, wr_data=8'hA7, wr_idx=5, written[5]=1; ptr=3.
- Round-robin fairness: req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,… and one wr_en pulse per cycle.
- Stall: req=4'b0011 with stall=1 for 3 cycles -> gnt=0, wr_en=0, ptr unchanged. Deassert stall -> gnt=4'b0001 (ptr=0).
- Clear/write collision: written=8'hFF, written_clr=1 in the same cycle as a grant to address 2 -> written=8'b0000_0100.
- Wrap-around: ptr=3, req=4'b0011 -> gnt=4'b0001, then ptr=1 -> gnt=4'b0010.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the shared 8-entry register-file write port.
// Grants one requester per cycle and registers the one-hot write enable, data and address.
module regfile_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [3*N_REQ-1:0]        req_addr,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    input  logic                      stall,
    output logic [N_REQ-1:0]          gnt,
    output logic [7:0]                wr_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic [2:0]                wr_idx,
    output logic [7:0]                written,
    input  logic                      written_clr
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]        ptr;
    logic [PW-1:0]        ptr_nxt;
    logic [PW-1:0]        win;
    logic                 found;
    logic [2*N_REQ-1:0]   req_rot2;
    logic [N_REQ-1:0]     req_rot;
    logic [PW:0]          sum;
    logic [PW:0]          nsum;
    logic [2:0]           addr_sel;
    logic [DATA_W-1:0]    data_sel;
    logic [7:0]           addr_dec;
    logic [7:0]           written_nxt;

    // Rotating a doubled copy of req puts the highest-priority requester at bit 0.
    always_comb begin
        req_rot2 = {req, req} >> ptr;
        req_rot  = req_rot2[N_REQ-1:0];
        found    = 1'b0;
        sum      = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (PW+1)'(j);
            end
        end
        if (sum >= (PW+1)'(N_REQ)) begin
            sum = sum - (PW+1)'(N_REQ);
        end
        win = sum[PW-1:0];
        // Reset and stall both suppress the grant, so nothing transfers on those edges.
        found = found && !stall && rst_n;
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = found && (win == PW'(i));
        end
    end

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                addr_sel = addr_sel | req_addr[3*i +: 3];
                data_sel = data_sel | req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        addr_dec           = '0;
        addr_dec[addr_sel] = 1'b1;
    end

    always_comb begin
        nsum = {1'b0, win} + (PW+1)'(1);
        if (nsum == (PW+1)'(N_REQ)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = nsum[PW-1:0];
        end
    end

    // Clear first, then the current write target, so a colliding write survives the clear.
    always_comb begin
        written_nxt = written_clr ? 8'h00 : written;
        if (found) begin
            written_nxt = written_nxt | addr_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            wr_en   <= '0;
            wr_data <= '0;
            wr_idx  <= '0;
            written <= '0;
        end else begin
            written <= written_nxt;
            if (found) begin
                ptr     <= ptr_nxt;
                wr_en   <= addr_dec;
                wr_data <= data_sel;
                wr_idx  <= addr_sel;
            end else begin
                wr_en   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (N_REQ=4, DATA_W=8) with hand-computed expectations.
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic        stall;
    logic [3:0]  gnt;
    logic [7:0]  wr_en;
    logic [7:0]  wr_data;
    logic [2:0]  wr_idx;
    logic [7:0]  written;
    logic        written_clr;

    int checks = 0;
    int errors = 0;

    regfile_wr_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .stall       (stall),
        .gnt         (gnt),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_idx      (wr_idx),
        .written     (written),
        .written_clr (written_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        req_addr[3*i +: 3] = a;
        req_data[8*i +: 8] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = 4'b1111;
        req_addr    = '0;
        req_data    = '0;
        stall       = 1'b0;
        written_clr = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 3'(i), 8'(8'h10 + i));
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_written", 32'(written), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_wr_idx", 32'(wr_idx), 32'h0);
        tick();
        chk("rst_hold_wr_en", 32'(wr_en), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Round robin with all four requesting; ptr starts at 0.
        for (int c = 0; c < 8; c++) begin
            chk("rr_gnt", 32'(gnt), 32'(1 << (c % 4)));
            tick();
            chk("rr_wr_en", 32'(wr_en), 32'(1 << (c % 4)));
            chk("rr_wr_data", 32'(wr_data), 32'(8'h10 + (c % 4)));
        end
        chk("rr_written", 32'(written), 32'h0F);

        // Idle: wr_en drops, data and index hold.
        req = 4'b0000;
        #1;
        chk("idle_gnt", 32'(gnt), 32'h0);
        tick();
        chk("idle_wr_en", 32'(wr_en), 32'h0);
        chk("idle_wr_data", 32'(wr_data), 32'h13);
        chk("idle_wr_idx", 32'(wr_idx), 32'h3);

        // Single request from requester 2 to register 5.
        set_req(2, 3'd5, 8'hA7);
        req = 4'b0100;
        #1;
        chk("single_gnt", 32'(gnt), 32'h4);
        tick();
        chk("single_wr_en", 32'(wr_en), 32'h20);
        chk("single_wr_data", 32'(wr_data), 32'hA7);
        chk("single_wr_idx", 32'(wr_idx), 32'h5);
        chk("single_written", 32'(written), 32'h2F);

        // Wrap-around from ptr=3.
        req = 4'b0011;
        #1;
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        tick();
        chk("wrap_wr_en0", 32'(wr_en), 32'h01);
        chk("wrap_gnt1", 32'(gnt), 32'h2);
        tick();
        chk("wrap_wr_en1", 32'(wr_en), 32'h02);

        // Stall for three cycles; ptr is 2 and must not move.
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_gnt", 32'(gnt), 32'h0);
            tick();
            chk("stall_wr_en", 32'(wr_en), 32'h0);
        end
        stall = 1'b0;
        req = 4'b1111;
        #1;
        chk("stall_ptr_kept", 32'(gnt), 32'h4);
        req = 4'b0011;
        #1;
        chk("unstall_gnt", 32'(gnt), 32'h1);
        tick();
        chk("unstall_wr_en", 32'(wr_en), 32'h01);

        // Fill the remaining registers 4,6,7; ptr=1 so order is 1,2,0.
        set_req(0, 3'd4, 8'h40);
        set_req(1, 3'd6, 8'h60);
        set_req(2, 3'd7, 8'h70);
        req = 4'b0111;
        #1;
        chk("fill_gnt", 32'(gnt), 32'h2);
        tick();
        chk("fill_wr_data", 32'(wr_data), 32'h60);
        tick();
        tick();
        chk("fill_last_wr_idx", 32'(wr_idx), 32'h4);
        chk("fill_written", 32'(written), 32'hFF);

        // Clear colliding with a write to register 2; ptr is 1 so requester 2 wins.
        set_req(2, 3'd2, 8'h5C);
        req = 4'b0100;
        written_clr = 1'b1;
        #1;
        chk("clr_gnt", 32'(gnt), 32'h4);
        tick();
        chk("clr_written", 32'(written), 32'h04);
        chk("clr_wr_en", 32'(wr_en), 32'h04);
        chk("clr_wr_data", 32'(wr_data), 32'h5C);
        req = 4'b0000;
        tick();
        chk("clr_only_written", 32'(written), 32'h00);
        written_clr = 1'b0;

        // Two requesters to register 3 on consecutive cycles; ptr=3 so requester 0 first.
        set_req(0, 3'd3, 8'h31);
        set_req(1, 3'd3, 8'h32);
        req = 4'b0011;
        tick();
        chk("same_wr_data0", 32'(wr_data), 32'h31);
        chk("same_wr_en0", 32'(wr_en), 32'h08);
        req = 4'b0010;
        tick();
        chk("same_wr_data1", 32'(wr_data), 32'h32);
        chk("same_wr_en1", 32'(wr_en), 32'h08);

        // Withdrawn request: stalled, then dropped, leaves no trace.
        set_req(3, 3'd6, 8'hEE);
        req = 4'b1000;
        stall = 1'b1;
        tick();
        req = 4'b0000;
        stall = 1'b0;
        tick();
        chk("withdraw_written", 32'(written), 32'h08);
        chk("withdraw_wr_data", 32'(wr_data), 32'h32);

        // Asynchronous reset mid-operation.
        set_req(0, 3'd6, 8'h66);
        req = 4'b0001;
        tick();
        chk("pre_rst_wr_en", 32'(wr_en), 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'h0);
        chk("async_rst_wr_en", 32'(wr_en), 32'h0);
        chk("async_rst_written", 32'(written), 32'h0);
        chk("async_rst_wr_data", 32'(wr_data), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
